// File: rtl/shift_sequencer.sv
// Iterative shift sequencer: drives an external combinational shifter for
// 'amount' passes (SRA1 or SLL8), feeding each pass's result back as the
// next pass's operand, then registers the final value and pulses done.
//
// Handshake: start is a level request that is only looked at in IDLE;
// there is no ready output and no queuing. Anything on start while busy
// or done is high is dropped. operand/op/amount are captured on the same
// edge that accepts start and are not looked at again until the next launch.
module shift_sequencer #(
  parameter int NBITS     = 32,
  parameter int S_CONTROL = 2,
  localparam int CNT_W    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        op,
  input  logic [CNT_W-1:0]            amount,
  input  logic signed [NBITS-1:0]     operand,
  output logic signed [NBITS-1:0]     sh_y,
  output logic [S_CONTROL-1:0]        sh_ctrl,
  input  logic signed [NBITS-1:0]     sh_c,
  output logic                        busy,
  output logic                        done,
  output logic signed [NBITS-1:0]     result,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic signed [NBITS-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     op_q;

  // cnt == 1 marks the final pass; <= 1 also keeps a corrupted zero count
  // from looping forever.
  logic last_pass;
  assign last_pass = (cnt <= CNT_W'(1));

  // The shifter always sees the accumulator, whatever the state.
  assign sh_y      = acc;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (last_pass) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; 2'b11 is never produced.
  always_comb begin
    sh_ctrl = S_CONTROL'(2'b00);
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      SHIFT: begin
        sh_ctrl = op_q ? S_CONTROL'(2'b10) : S_CONTROL'(2'b01);
        busy    = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        sh_ctrl = S_CONTROL'(2'b00);
      end
    endcase
  end

  // Datapath: capture on launch, iterate through the shifter, latch result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      op_q   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= operand;
            cnt  <= amount;
            op_q <= op;
            if (amount == '0) begin
              result <= operand;
            end
          end
        end
        SHIFT: begin
          acc <= sh_c;
          cnt <= cnt - CNT_W'(1);
          if (last_pass) begin
            result <= sh_c;
          end
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external shifter, launches directed
// and random operations, and compares results against an arithmetic model.
module tb_shift_sequencer;

  logic               clk;
  logic               reset;
  logic               start;
  logic               op;
  logic [4:0]         amount;
  logic signed [31:0] operand;
  logic signed [31:0] sh_y;
  logic [1:0]         sh_ctrl;
  logic signed [31:0] sh_c;
  logic               busy;
  logic               done;
  logic signed [31:0] result;
  logic [1:0]         state_dbg;

  int errs   = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .amount    (amount),
    .operand   (operand),
    .sh_y      (sh_y),
    .sh_ctrl   (sh_ctrl),
    .sh_c      (sh_c),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // External shifter: combinational from sh_y / sh_ctrl.
  always_comb begin
    case (sh_ctrl)
      2'b10:   sh_c = sh_y << 8;
      2'b01:   sh_c = sh_y >>> 1;
      default: sh_c = sh_y;
    endcase
  end

  // Reference: the whole operation as one arithmetic shift.
  function automatic logic [31:0] ref_shift(input bit o, input int amt, input logic [31:0] v);
    logic signed [31:0] sv;
    sv = v;
    if (o) return (amt >= 4) ? 32'h0 : (v << (8 * amt));
    return sv >>> amt;
  endfunction

  // Launch one operation and follow it to completion, checking each cycle.
  task automatic run_op(input bit o, input int amt, input logic [31:0] v,
                        input logic [31:0] exp_val, input bit scramble);
    int cycles;
    int busy_cnt;
    logic [31:0] exp_r;
    logic [1:0]  exp_ctrl;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    amount  = amt[4:0];
    operand = v;
    exp_q.push_back(exp_val);
    exp_ctrl = o ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      op      = 1'($urandom);
      amount  = 5'($urandom);
      operand = $urandom;
    end
    cycles   = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 40) begin
      checks++;
      if (busy !== 1'b1 || sh_ctrl !== exp_ctrl) begin
        errs++;
        $display("FAIL shift_phase op=%0d amt=%0d cyc=%0d: busy=%b sh_ctrl=%b, want busy=1 sh_ctrl=%b",
                 o, amt, cycles, busy, sh_ctrl, exp_ctrl);
      end
      busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    exp_r = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL done_timeout op=%0d amt=%0d: done=%b after %0d cycles, want 1", o, amt, done, cycles);
    end
    checks++;
    if (cycles != amt + 1) begin
      errs++;
      $display("FAIL latency op=%0d amt=%0d: got %0d cycles, want %0d", o, amt, cycles, amt + 1);
    end
    checks++;
    if (busy_cnt != amt) begin
      errs++;
      $display("FAIL busy_cycles op=%0d amt=%0d: got %0d, want %0d", o, amt, busy_cnt, amt);
    end
    checks++;
    if (busy !== 1'b0 || sh_ctrl !== 2'b00) begin
      errs++;
      $display("FAIL done_outputs op=%0d amt=%0d: busy=%b sh_ctrl=%b, want 0/00", o, amt, busy, sh_ctrl);
    end
    checks++;
    if (result !== exp_r) begin
      errs++;
      $display("FAIL result op=%0d amt=%0d v=%h: got %h, want %h", o, amt, v, result, exp_r);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin
      errs++;
      $display("FAIL after_done op=%0d amt=%0d: done=%b busy=%b result=%h, want 0/0/%h",
               o, amt, done, busy, result, exp_r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    op = 1'b1; amount = 5'd3; operand = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sh_ctrl !== 2'b00 || result !== 32'h0 ||
        sh_y !== 32'h0 || state_dbg !== 2'd0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b sh_ctrl=%b result=%h sh_y=%h st=%0d, want all zero",
               busy, done, sh_ctrl, result, sh_y, state_dbg);
    end
    start = 1'b0;
    #1 reset = 1'b0;
    // First edge with reset low must accept the launch.
    run_op(1'b1, 2, 32'h0000_00AB, 32'h00AB_0000, 1'b0);
  endtask

  task automatic test_directed();
    run_op(1'b0, 4,  32'h8000_0000, 32'hF800_0000, 1'b1);
    run_op(1'b0, 4,  32'h4000_0000, 32'h0400_0000, 1'b1);
    run_op(1'b0, 0,  32'h1234_5678, 32'h1234_5678, 1'b1);
    run_op(1'b1, 0,  32'h1234_5678, 32'h1234_5678, 1'b1);
    run_op(1'b1, 5,  32'h1234_5678, 32'h0000_0000, 1'b1);
    run_op(1'b1, 3,  32'h1234_5678, 32'h7800_0000, 1'b1);
    run_op(1'b0, 31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(1'b0, 31, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit          o;
      int          amt;
      logic [31:0] v;
      o   = 1'($urandom);
      amt = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 31);
      v   = $urandom;
      run_op(o, amt, v, ref_shift(o, amt, v), 1'b1);
    end
  endtask

  // start pulsed during SHIFT and DONE with a different operand is dropped.
  task automatic test_busy_reject();
    int          dones;
    logic [31:0] exp_r;
    exp_r = ref_shift(1'b1, 3, 32'h0000_00CD);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start   = (i == 0 || i == 1 || i == 4);
      op      = (i == 0) ? 1'b1 : 1'b0;
      amount  = (i == 0) ? 5'd3 : 5'd1;
      operand = (i == 0) ? 32'h0000_00CD : 32'h5555_AAAA;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (i != 3) begin
          errs++;
          $display("FAIL reject_done_time: done at edge %0d, want edge 3", i);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dones != 1) begin
      errs++;
      $display("FAIL reject_done_count: got %0d done pulses, want 1", dones);
    end
    checks++;
    if (result !== exp_r) begin
      errs++;
      $display("FAIL reject_result: got %h, want %h", result, exp_r);
    end
  endtask

  // start held high: relaunches on the first IDLE cycle after DONE.
  task automatic test_back_to_back();
    int          hits;
    logic [31:0] exp_r;
    int          exp_idx[$];
    exp_q.delete();
    exp_q.push_back(ref_shift(1'b1, 1, 32'h0000_1234));
    exp_q.push_back(ref_shift(1'b1, 1, 32'h0000_0077));
    exp_idx.push_back(1);
    exp_idx.push_back(4);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start   = (i <= 4);
      op      = 1'b1;
      amount  = 5'd1;
      operand = (i == 0) ? 32'h0000_1234 : 32'h0000_0077;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        hits++;
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL b2b_extra_done: unexpected done at edge %0d", i);
        end else begin
          exp_r = exp_q.pop_front();
          if (result !== exp_r || i != exp_idx[0]) begin
            errs++;
            $display("FAIL b2b_done: edge %0d result %h, want edge %0d result %h",
                     i, result, exp_idx[0], exp_r);
          end
          void'(exp_idx.pop_front());
        end
      end
    end
    start = 1'b0;
    checks++;
    if (hits != 2) begin
      errs++;
      $display("FAIL b2b_count: got %0d done pulses, want 2", hits);
    end
    exp_q.delete();
  endtask

  // Reset in the 2nd SHIFT cycle discards the operation.
  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 1'b1; amount = 5'd3; operand = 32'h0000_00AB;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sh_ctrl !== 2'b00 || result !== 32'h0 ||
        sh_y !== 32'h0 || state_dbg !== 2'd0) begin
      errs++;
      $display("FAIL reset_mid: busy=%b done=%b sh_ctrl=%b result=%h sh_y=%h st=%0d, want all zero",
               busy, done, sh_ctrl, result, sh_y, state_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1 || result !== 32'h0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errs++;
      $display("FAIL reset_discard: %0d cycles with activity after reset, want 0", dones);
    end
    run_op(1'b1, 3, 32'h0000_00AB, 32'hAB00_0000, 1'b1);
  endtask

  initial begin
    start = 1'b0; op = 1'b0; amount = '0; operand = '0; reset = 1'b1;
    test_reset();
    test_directed();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL take NBITS and S_CONTROL from the shared definitions header: NBITS = 32 (datapath word width), S_CONTROL = 2 (shifter control width).
REQ-002 SHALL have local parameter CNT_W, default 5, meaning the width of the pass-count field.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a shift operation; sampled only in IDLE.
REQ-007 op  input  1  0 = repeated SRA1, 1 = repeated SLL8.
REQ-008 amount  input  CNT_W  number of shifter passes (0-31).
REQ-009 operand  input  NBITS signed  value to shift.
REQ-010 sh_y  output  NBITS signed  operand driven to the shifter.
REQ-011 sh_ctrl  output  S_CONTROL  shifter control: 2'b00 = pass, 2'b10 = SLL8, 2'b01 = SRA1.
REQ-012 sh_c  input  NBITS signed  result returned by the shifter (combinational from sh_y/sh_ctrl).
REQ-013 busy  output  1  high while passes are in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 result  output  NBITS signed  registered final value.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE with internal registers acc (NBITS), cnt (CNT_W) and op_q.
REQ-017 IDLE: sh_ctrl = 2'b00; busy = 0; done = 0.
REQ-018 IDLE with start = 1: acc <= operand, cnt <= amount, op_q <= op; next state SHIFT if amount != 0, else DONE with result <= operand.
REQ-019 SHIFT: sh_y = acc; sh_ctrl = op_q ? 2'b10 : 2'b01; busy = 1; each cycle acc <= sh_c, cnt <= cnt - 1.
REQ-020 SHIFT with cnt == 1: result <= sh_c; next state DONE.
REQ-021 DONE: done = 1 and busy = 0 for exactly one cycle; sh_ctrl = 2'b00; next state IDLE unconditionally.
REQ-022 Latency SHALL be exactly amount + 1 cycles from the start-sampling edge to the done cycle; amount = 0 gives 1 cycle.
REQ-023 start SHALL be ignored in SHIFT and DONE, with no queuing; a start held high re-launches on the first IDLE cycle.
REQ-024 operand, op and amount SHALL be sampled only at the launch edge; later changes SHALL NOT affect an operation in flight.
REQ-025 result SHALL hold its value from one DONE until the next result load.
REQ-026 No saturation logic SHALL be added: SLL8 with amount >= 4 yields 0; SRA1 with amount >= 31 yields sign fill. Both fall out of the iteration.
REQ-027 sh_y SHALL equal acc in every state; sh_ctrl SHALL be 2'b11 in no state.

Reset
REQ-028 reset asserted in any state SHALL immediately force state = IDLE, acc = 0, cnt = 0, op_q = 0, result = 0, busy = 0, done = 0, sh_ctrl = 2'b00.
REQ-029 An operation interrupted by reset SHALL be discarded: no done pulse and no result update after reset release.
REQ-030 The first start SHALL be accepted on the first rising edge with reset low.

Verification
REQ-031 SLL8: operand = 0x000000AB, op = 1, amount = 2 -> busy for 2 cycles, sh_ctrl = 2'b10 in both; done 3 cycles after start; result = 0x00AB0000.
REQ-032 SRA1: operand = 0x80000000, op = 0, amount = 4 -> done after 5 cycles; result = 0xF8000000; SRA1 on 0x40000000 with amount = 4 -> 0x04000000.
REQ-033 Zero passes: operand = 0x12345678, amount = 0 -> sh_ctrl stays 2'b00, done 1 cycle after start, result = 0x12345678.
REQ-034 Boundaries: SLL8 with amount = 5 on 0x12345678 -> result = 0; SRA1 with amount = 31 on 0xFFFFFFFF -> 0xFFFFFFFF (done after 32 cycles).
REQ-035 Busy rejection: second start with a different operand pulsed in SHIFT and DONE -> ignored; first result unchanged; exactly one done pulse.
REQ-036 Reset mid-operation: SLL8 with amount = 3, reset asserted in the 2nd SHIFT cycle -> outputs zeroed asynchronously, no done; next start completes normally.
